// File: rtl/uart_pkg.sv
// Constants and state type shared by the 128-bit UART link transmitter and receiver.
package uart_pkg;
    localparam int CLOCK_PER_BIT_DEFAULT = 10417;
    localparam int BLOCK_BITS            = 128;
    localparam int BYTE_BITS             = 8;
    localparam int NUM_BYTES_DEFAULT     = BLOCK_BITS / BYTE_BITS;
    localparam int TIMER_W               = 24;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;
endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..CLOCK_PER_BIT-1 and flags the last cycle of each period.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int CLOCK_PER_BIT = CLOCK_PER_BIT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);
    localparam logic [TIMER_W-1:0] LAST = TIMER_W'(CLOCK_PER_BIT - 1);

    logic [TIMER_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = !clear && (count == LAST);
endmodule

// File: rtl/uart_block_tx.sv
// Serialises one 128-bit block as 16 8N1 frames, most-significant byte first.
module uart_block_tx
    import uart_pkg::*;
#(
    parameter int CLOCK_PER_BIT = CLOCK_PER_BIT_DEFAULT,
    parameter int NUM_BYTES     = NUM_BYTES_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [BLOCK_BITS-1:0] data_in,
    input  logic                  send,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);
    localparam logic [3:0] LAST_BYTE = 4'(NUM_BYTES - 1);

    uart_state_t           state;
    logic [BLOCK_BITS-1:0] shreg;
    logic [2:0]            bit_cnt;
    logic [3:0]            byte_cnt;
    logic                  finish;
    logic                  tick;
    logic [BYTE_BITS-1:0]  cur_byte;

    assign cur_byte = shreg[BLOCK_BITS-1 -: BYTE_BITS];

    uart_bit_timer #(
        .CLOCK_PER_BIT(CLOCK_PER_BIT)
    ) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .clear(state == IDLE),
        .tick (tick)
    );

    // tx is driven from the state held during the previous cycle, so it trails the
    // FSM by one clock; finish delays done/busy-release by the same cycle to stay aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            finish   <= 1'b0;
            tx       <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            finish <= 1'b0;
            done   <= finish;
            if (finish) begin
                busy <= 1'b0;
            end
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (send && !busy) begin
                        shreg    <= data_in;
                        byte_cnt <= '0;
                        bit_cnt  <= '0;
                        busy     <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    tx <= 1'b0;
                    if (tick) begin
                        bit_cnt <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    tx <= cur_byte[bit_cnt];
                    if (tick) begin
                        if (bit_cnt == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                end
                STOP: begin
                    tx <= 1'b1;
                    if (tick) begin
                        if (byte_cnt == LAST_BYTE) begin
                            state  <= IDLE;
                            finish <= 1'b1;
                        end else begin
                            shreg    <= shreg << BYTE_BITS;
                            byte_cnt <= byte_cnt + 4'd1;
                            state    <= START;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_block_tx.sv
// Self-checking bench for uart_block_tx with CLOCK_PER_BIT=4.
module tb_uart_block_tx;
    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;
    localparam int BLOCK = 16 * FRAME;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] data_in;
    logic         send;
    logic         tx;
    logic         busy;
    logic         done;

    int n_vec = 0;
    int n_err = 0;

    uart_block_tx #(.CLOCK_PER_BIT(CPB), .NUM_BYTES(16)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .data_in(data_in),
        .send   (send),
        .tx     (tx),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] data;
        logic [9:0]   frame0;
    } vec_t;

    vec_t tab[3];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end else begin
            $display("ok   %s: %h", nm, act);
        end
    endtask

    // Reference line value k cycles after the first start-bit cycle.
    function automatic logic model_bit(input logic [127:0] d, input int k);
        int f;
        int b;
        logic [7:0] byte_v;
        f = k / FRAME;
        b = (k % FRAME) / CPB;
        byte_v = d[127 - 8*f -: 8];
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return byte_v[b-1];
    endfunction

    task automatic pulse_send(input logic [127:0] d);
        @(negedge clk);
        data_in = d;
        send    = 1'b1;
        @(negedge clk);
        send    = 1'b0;
        data_in = {$urandom, $urandom, $urandom, $urandom};
    endtask

    // Records one block from the tx line, compares it with the model, and decodes it.
    task automatic capture(input logic [127:0] exp, input int poke_at, input logic [127:0] poke_data,
                           input bit hold, input logic [127:0] next_data,
                           output logic [127:0] word, output logic [9:0] frame0);
        logic s[BLOCK];
        int t = 0;
        int bad = 0;
        int dones = 0;
        int busy_low = 0;
        word = '0;
        frame0 = '0;
        while (tx !== 1'b0 && t < 8) begin
            @(negedge clk);
            t++;
        end
        chk("fall_latency", t, 1);
        if (tx !== 1'b0) return;
        for (int i = 0; i < BLOCK; i++) begin
            s[i] = tx;
            if (tx !== model_bit(exp, i)) bad++;
            if (done !== 1'b0) dones++;
            if (busy !== 1'b1) busy_low++;
            if (i == poke_at) begin
                send    = 1'b1;
                data_in = poke_data;
            end else if (poke_at >= 0 && i == poke_at + 1) begin
                send = 1'b0;
            end
            @(negedge clk);
        end
        chk("waveform_miss", bad, 0);
        chk("early_done", dones, 0);
        chk("busy_gap", busy_low, 0);
        chk("done_at_640", {done, busy}, 2'b10);
        if (hold) data_in = next_data;
        else send = 1'b0;
        @(negedge clk);
        chk("done_width", done, 1'b0);
        for (int j = 0; j < 10; j++) frame0[j] = s[CPB*j + CPB/2];
        for (int f = 0; f < 16; f++)
            for (int j = 0; j < 8; j++)
                word[120 - 8*f + j] = s[FRAME*f + CPB*(j+1) + CPB/2];
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        logic [127:0] w;
        logic [9:0]   f0;
        logic [127:0] d;
        int           cnt;

        tab[0] = '{128'h000102030405060708090A0B0C0D0E0F, 10'b1000000000};
        tab[1] = '{128'hA5112233445566778899AABBCCDDEEFF, 10'b1101001010};
        tab[2] = '{128'h3243F6A8885A308D313198A2E0370734, 10'b1001100100};

        rst_n = 1'b0;
        send = 1'b0;
        data_in = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {tx, busy, done}, 3'b100);
        rst_n = 1'b1;
        cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) cnt++;
        end
        chk("idle_after_reset", cnt, 0);

        for (int i = 0; i < 3; i++) begin
            pulse_send(tab[i].data);
            capture(tab[i].data, -1, '0, 1'b0, '0, w, f0);
            chk("table_word", w, tab[i].data);
            chk("table_frame0", f0, tab[i].frame0);
        end

        // A second request 50 cycles into a block must be dropped, not queued.
        d = 128'h0123456789ABCDEF_FEDCBA9876543210;
        pulse_send(d);
        capture(d, 50, ~d, 1'b0, '0, w, f0);
        chk("ignore_word", w, d);
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) cnt++;
        end
        chk("ignore_no_second", cnt, 0);

        // send held high across two blocks.
        @(negedge clk);
        data_in = {128{1'b1}};
        send    = 1'b1;
        @(negedge clk);
        capture({128{1'b1}}, -1, '0, 1'b1, '0, w, f0);
        chk("b2b_word1", w, {128{1'b1}});
        chk("b2b_rebusy", busy, 1'b1);
        capture('0, -1, '0, 1'b0, '0, w, f0);
        chk("b2b_word2", w, 128'h0);
        chk("b2b_end_busy", busy, 1'b0);

        for (int r = 0; r < 4; r++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            pulse_send(d);
            capture(d, -1, '0, 1'b0, '0, w, f0);
            chk("rand_word", w, d);
        end

        // Reset during the start bit of byte 7.
        d = {$urandom, $urandom, $urandom, $urandom};
        pulse_send(d);
        @(negedge clk);
        repeat (7 * FRAME) @(negedge clk);
        chk("pre_reset_tx", tx, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", {tx, busy, done}, 3'b100);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (30) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) cnt++;
        end
        chk("post_reset_idle", cnt, 0);
        d = {$urandom, $urandom, $urandom, $urandom};
        pulse_send(d);
        capture(d, -1, '0, 1'b0, '0, w, f0);
        chk("recovery_word", w, d);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
